// File: rtl/arith_pkg.sv
// Shared arithmetic-library types: FSM state encoding and counter sizing.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed for a counter that can hold 0..width inclusive.
    function automatic int CNT_W(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// 1-bit full subtractor cell: D = A - B - Bin, with borrow out.
module full_subtractor (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic D,
    output logic Bout
);

    assign D    = A ^ B ^ Bin;
    assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first,
// through a single full_subtractor cell with a registered borrow loop.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = CNT_W(WIDTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_d_sh;
    logic             r_brw;
    logic [CW-1:0]    r_cnt;

    logic             w_d;
    logic             w_bout;
    logic             w_last;

    // The one and only arithmetic cell; operands come from the shift LSBs.
    full_subtractor u_cell (
        .A    (r_a_sh[0]),
        .B    (r_b_sh[0]),
        .Bin  (r_brw),
        .D    (w_d),
        .Bout (w_bout)
    );

    // Last bit is being processed when the counter reaches WIDTH-1; r_brw is
    // then the borrow into the MSB, needed for signed overflow.
    assign w_last = (r_cnt == CW'(WIDTH - 1));

    // FSM plus datapath: load on start, shift during RUN, publish on the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_d_sh  <= '0;
            r_brw   <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            diff    <= '0;
            bout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_d_sh  <= '0;
                        r_brw   <= bin;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_d_sh <= {w_d, r_d_sh[WIDTH-1:1]};
                    r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_brw  <= w_bout;
                    r_cnt  <= r_cnt + 1'b1;
                    if (w_last) begin
                        diff    <= {w_d, r_d_sh[WIDTH-1:1]};
                        bout    <= w_bout;
                        ovf     <= r_brw ^ w_bout;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
